// File: rtl/sap_cpu_param.sv
// Parametrised SAP hardwired CPU: run-time loadable program memory and a 6-state one-hot ring
// sequencer for variable-length instructions, with zero and carry flags.
module sap_cpu_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] pc,
  output logic [5:0]        t_state,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if (DATA_W < 4 + ADDR_W) begin : g_bad_width
    $error("sap_cpu_param: DATA_W must hold a 4-bit opcode plus an ADDR_W-bit operand");
  end

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpSta = 4'h3;
  localparam logic [3:0] OpLdi = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJc  = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [1:0] {StIdle, StExec, StHalt} state_e;

  state_e              state_q, state_d;
  logic [5:0]          ring_q, ring_d;
  logic [ADDR_W-1:0]   pc_q, mar_q;
  logic [DATA_W-1:0]   acc_q, b_q, ir_q, out_q;
  logic                z_q, c_q, out_valid_q;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   op_arg;
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W-1:0]   diff;
  logic                two_operand;
  logic                last_step;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign opcode  = ir_q[ADDR_W+3:ADDR_W];
  assign op_arg  = ir_q[ADDR_W-1:0];
  assign mem_rd  = mem_q[mar_q];
  assign sum_ext = {1'b0, acc_q} + {1'b0, b_q};
  assign diff    = acc_q - b_q;

  // Instructions that spend T4 loading MAR and continue into T5.
  assign two_operand = (opcode == OpLda) || (opcode == OpAdd) ||
                       (opcode == OpSub) || (opcode == OpSta);

  always_comb begin
    last_step = 1'b0;
    if (ring_q[3]) last_step = !two_operand;
    if (ring_q[4]) last_step = (opcode == OpLda) || (opcode == OpSta);
    if (ring_q[5]) last_step = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StExec;
          ring_d  = 6'b000001;
        end
      end
      StExec: begin
        if (ring_q[3] && (opcode == OpHlt)) begin
          state_d = StHalt;
          ring_d  = '0;
        end else if (last_step) begin
          if (run) begin
            ring_d = 6'b000001;
          end else begin
            state_d = StIdle;
            ring_d  = '0;
          end
        end else begin
          ring_d = {ring_q[4:0], 1'b0};
        end
      end
      StHalt: begin
        ring_d = '0;
      end
      default: begin
        state_d = StIdle;
        ring_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ring_q  <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
    end
  end

  // The loader may only write while the core is not sequencing an instruction.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (ring_q[4] && (opcode == OpSta)) begin
      mem_we    = 1'b1;
      mem_waddr = mar_q;
      mem_wdata = acc_q;
    end else if (prog_we && (state_q != StExec)) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      mar_q       <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (ring_q[0]) mar_q <= pc_q;
      if (ring_q[1]) pc_q  <= pc_q + ADDR_W'(1);
      if (ring_q[2]) ir_q  <= mem_rd;
      if (ring_q[3]) begin
        case (opcode)
          OpLda, OpAdd, OpSub, OpSta: mar_q <= op_arg;
          OpLdi: begin
            acc_q <= DATA_W'(op_arg);
            z_q   <= (op_arg == '0);
          end
          OpJmp: pc_q <= op_arg;
          OpJc:  if (c_q) pc_q <= op_arg;
          OpJz:  if (z_q) pc_q <= op_arg;
          OpOut: begin
            out_q       <= acc_q;
            out_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (ring_q[4]) begin
        case (opcode)
          OpLda: begin
            acc_q <= mem_rd;
            z_q   <= (mem_rd == '0);
          end
          OpAdd, OpSub: b_q <= mem_rd;
          default: ;
        endcase
      end
      if (ring_q[5]) begin
        if (opcode == OpSub) begin
          acc_q <= diff;
          z_q   <= (diff == '0);
          c_q   <= (acc_q >= b_q);
        end else begin
          acc_q <= sum_ext[DATA_W-1:0];
          z_q   <= (sum_ext[DATA_W-1:0] == '0);
          c_q   <= sum_ext[DATA_W];
        end
      end
    end
  end

  assign pc        = pc_q;
  assign t_state   = ring_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_sap_cpu_param.sv
// Self-checking bench for sap_cpu_param (DATA_W=8, ADDR_W=4): directed scenarios plus random
// programs compared against an instruction-level reference model.
module tb_sap_cpu_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] pc;
  logic [5:0] t_state;
  logic [7:0] out_data;
  logic       out_valid, flag_z, flag_c, halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [16];
  int         exp_halt;
  logic [3:0] exp_pc;
  logic       exp_z, exp_c, model_halts;
  int         exp_cyc [$];
  logic [7:0] exp_val [$];
  int         obs_halt;
  int         obs_cyc [$];
  logic [7:0] obs_val [$];

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .pc        (pc),
    .t_state   (t_state),
    .out_data  (out_data),
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level model: cycle cost per instruction, sample index 0 = first T1.
  task automatic model_run();
    logic [7:0] m [16];
    logic [7:0] acc, ir;
    logic [8:0] s;
    logic [3:0] pcm, a;
    logic       z, c;
    int         cyc;
    for (int i = 0; i < 16; i++) m[i] = prog[i];
    acc = 8'h00; pcm = 4'h0; z = 1'b0; c = 1'b0; cyc = 0;
    exp_cyc.delete(); exp_val.delete(); model_halts = 1'b0; exp_halt = -1;
    for (int n = 0; n < 400 && !model_halts; n++) begin
      ir  = m[pcm];
      pcm = pcm + 4'd1;
      a   = ir[3:0];
      case (ir[7:4])
        4'h0: begin acc = m[a]; z = (acc == 8'h00); cyc += 5; end
        4'h1: begin
          s = {1'b0, acc} + {1'b0, m[a]};
          c = s[8]; acc = s[7:0]; z = (acc == 8'h00); cyc += 6;
        end
        4'h2: begin c = (acc >= m[a]); acc = acc - m[a]; z = (acc == 8'h00); cyc += 6; end
        4'h3: begin m[a] = acc; cyc += 5; end
        4'h4: begin acc = {4'h0, a}; z = (a == 4'h0); cyc += 4; end
        4'h5: begin pcm = a; cyc += 4; end
        4'h6: begin if (c) pcm = a; cyc += 4; end
        4'h7: begin if (z) pcm = a; cyc += 4; end
        4'hE: begin exp_cyc.push_back(cyc + 4); exp_val.push_back(acc); cyc += 4; end
        4'hF: begin exp_halt = cyc + 4; model_halts = 1'b1; end
        default: cyc += 4;
      endcase
    end
    exp_pc = pcm; exp_z = z; exp_c = c;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic exec_prog(input int budget);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; run = 1'b1;
    obs_cyc.delete(); obs_val.delete(); obs_halt = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin obs_cyc.push_back(n); obs_val.push_back(out_data); end
      if (halted) begin obs_halt = n; break; end
    end
    @(negedge clk); run = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_halt_cycle"}, obs_halt, exp_halt);
    chk({tag, "_out_count"}, obs_val.size(), exp_val.size());
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      chk({tag, "_out_val"}, obs_val[i], exp_val[i]);
      chk({tag, "_out_cycle"}, obs_cyc[i], exp_cyc[i]);
    end
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_z"}, flag_z, exp_z);
    chk({tag, "_c"}, flag_c, exp_c);
    chk({tag, "_tstate_halt"}, t_state, 6'h00);
    chk({tag, "_halted"}, halted, 1'b1);
  endtask

  task automatic clear_prog(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) prog[i] = fill;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 4'h0);
    chk("reset_tstate", t_state, 6'h00);
    chk("reset_out", {out_valid, out_data, flag_z, flag_c, halted}, 12'h000);
    @(negedge clk); rst = 1'b0;

    // Scenario 1: LDA/ADD/ADD/SUB/OUT/HLT
    clear_prog(8'h00);
    prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h1B; prog[3] = 8'h2B;
    prog[4] = 8'hE0; prog[5] = 8'hF0; prog[9] = 8'h01; prog[10] = 8'h02; prog[11] = 8'h03;
    load_prog(); model_run(); exec_prog(200); compare_model("s1");
    chk("s1_out_count_fixed", obs_val.size(), 1);
    if (obs_val.size() > 0) chk("s1_out_fixed", obs_val[0], 8'h03);
    chk("s1_halt_31", obs_halt, 31);
    chk("s1_zc", {flag_z, flag_c}, 2'b01);

    // Scenario 5: async reset at T5 of the first ADD, then rerun from retained memory
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; run = 1'b1;
    for (int n = 0; n <= 9; n++) begin @(posedge clk); #1; end
    chk("s5_at_add_t5", t_state, 6'b010000);
    chk("s5_pc_before", pc, 4'h2);
    rst = 1'b1; #1;
    chk("s5_rst_tstate", t_state, 6'h00);
    chk("s5_rst_pc", pc, 4'h0);
    chk("s5_rst_outs", {out_valid, out_data, flag_z, flag_c, halted}, 12'h000);
    @(negedge clk); rst = 1'b0; run = 1'b0;
    exec_prog(200); compare_model("s5");

    // Scenario 6: drop run in ADD T2, loader write in T3 must be ignored, then resume
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; run = 1'b1;
    for (int n = 0; n <= 6; n++) begin @(posedge clk); #1; end
    chk("s6_add_t2", t_state, 6'b000010);
    run = 1'b0;
    @(posedge clk); #1;
    chk("s6_add_t3", t_state, 6'b000100);
    prog_we = 1'b1; prog_addr = 4'hB; prog_data = 8'h77;
    @(posedge clk); #1;
    prog_we = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("s6_idle_tstate", t_state, 6'h00);
    chk("s6_idle_pc", pc, 4'h2);
    repeat (3) begin @(posedge clk); #1; end
    chk("s6_pc_stable", pc, 4'h2);
    chk("s6_not_halted", halted, 1'b0);
    run = 1'b1;
    obs_val.delete(); obs_halt = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) obs_val.push_back(out_data);
      if (halted) begin obs_halt = n; break; end
    end
    chk("s6_resume_halted", halted, 1'b1);
    chk("s6_resume_count", obs_val.size(), 1);
    if (obs_val.size() > 0) chk("s6_resume_out", obs_val[0], 8'h03);
    @(negedge clk); run = 1'b0;

    // Scenario 2: LDI/STA/LDA/OUT/HLT
    clear_prog(8'h00);
    prog[0] = 8'h45; prog[1] = 8'h3F; prog[2] = 8'h0F; prog[3] = 8'hE0; prog[4] = 8'hF0;
    load_prog(); model_run(); exec_prog(200); compare_model("s2");
    if (obs_val.size() > 0) chk("s2_out_fixed", obs_val[0], 8'h05);
    chk("s2_z", flag_z, 1'b0);

    // Scenario 3: carry out to zero, JC taken
    clear_prog(8'h00);
    prog[0] = 8'h08; prog[1] = 8'h19; prog[2] = 8'h66; prog[3] = 8'hF0;
    prog[6] = 8'hE0; prog[7] = 8'hF0; prog[8] = 8'hFF; prog[9] = 8'h01;
    load_prog(); model_run(); exec_prog(200); compare_model("s3");
    if (obs_val.size() > 0) chk("s3_out_fixed", obs_val[0], 8'h00);
    chk("s3_zc", {flag_z, flag_c}, 2'b11);
    chk("s3_pc", pc, 4'h8);

    // Scenario 4: JZ not taken, JMP to F, pc wraps after fetching F
    clear_prog(8'hF0);
    prog[0] = 8'h47; prog[1] = 8'h7A; prog[2] = 8'h5F;
    load_prog(); model_run(); exec_prog(200); compare_model("s4");
    chk("s4_halt_16", obs_halt, 16);
    chk("s4_pc_wrap", pc, 4'h0);

    // Random programs that the model shows halt
    for (int r = 0; r < 10; r++) begin
      do begin
        for (int i = 0; i < 16; i++) begin
          prog[i] = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 5) == 0) prog[i][7:4] = 4'hE;
          else if ($urandom_range(0, 7) == 0) prog[i][7:4] = 4'hF;
        end
        model_run();
      end while (!model_halts || exp_halt > 1500);
      load_prog(); exec_prog(2000); compare_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
